// File: rtl/memory_write_split.sv
// Splits one execute-side memory write into at most two TLB write pieces so that
// no piece crosses a LINE_BYTES boundary; tracks sticky page/alignment faults.
module memory_write_split #(
  parameter int LINE_BYTES = 16,
  parameter int MAX_BYTES  = 4,
  localparam int DW = 8 * MAX_BYTES,
  localparam int LW = $clog2(MAX_BYTES + 1),
  localparam int OW = $clog2(LINE_BYTES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_reset,
  input  logic          i_write_do,
  output logic          o_write_done,
  output logic          o_write_page_fault,
  output logic          o_write_ac_fault,
  output logic          o_write_fault_second,
  input  logic [1:0]    i_write_cpl,
  input  logic [31:0]   i_write_address,
  input  logic [LW-1:0] i_write_length,
  input  logic          i_write_lock,
  input  logic          i_write_rmw,
  input  logic [DW-1:0] i_write_data,
  output logic          o_tlbwrite_do,
  input  logic          i_tlbwrite_done,
  input  logic          i_tlbwrite_page_fault,
  input  logic          i_tlbwrite_ac_fault,
  output logic [1:0]    o_tlbwrite_cpl,
  output logic          o_tlbwrite_lock,
  output logic          o_tlbwrite_rmw,
  output logic [LW-1:0] o_tlbwrite_length_full,
  output logic [31:0]   o_tlbwrite_address,
  output logic [LW-1:0] o_tlbwrite_length,
  output logic [DW-1:0] o_tlbwrite_data,
  output logic [MAX_BYTES-1:0] o_tlbwrite_be,
  output logic          o_tlbwrite_second
);

  // state    | meaning
  // S_IDLE   | waiting for write_do; piece 1 fields presented from the inputs
  // S_FIRST  | piece 1 outstanding at the TLB
  // S_SECOND | registered piece 2 outstanding at the TLB
  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_SECOND} state_t;

  localparam logic [OW:0] C_LINE = (OW + 1)'(LINE_BYTES);

  state_t        r_state, w_next;
  logic [LW-1:0] r_len2;
  logic [31:0]   r_addr2;
  logic [DW-1:0] r_data2;
  logic          r_reset_waiting;
  logic          r_page_fault, r_ac_fault, r_fault_second;

  logic [OW:0]   w_left, w_len_ext;
  logic [LW-1:0] w_len1, w_len2;
  logic [31:0]   w_addr2;
  logic [DW-1:0] w_data2;
  logic          w_busy, w_tlb_fault, w_live_pf, w_live_ac, w_accept;

  assign w_left    = C_LINE - {1'b0, i_write_address[OW-1:0]};
  assign w_len_ext = (OW + 1)'(i_write_length);
  assign w_len1    = (w_len_ext < w_left) ? i_write_length : LW'(w_left);
  assign w_len2    = i_write_length - w_len1;
  assign w_addr2   = {i_write_address[31:OW], {OW{1'b0}}} + 32'(LINE_BYTES);
  assign w_data2   = i_write_data >> {w_len1, 3'b000};

  // Responses arriving after a wr_reset belong to an aborted write and are dropped.
  assign w_busy      = (r_state != S_IDLE);
  assign w_tlb_fault = i_tlbwrite_page_fault | i_tlbwrite_ac_fault;
  assign w_live_pf   = w_busy & ~r_reset_waiting & i_tlbwrite_page_fault;
  assign w_live_ac   = w_busy & ~r_reset_waiting & i_tlbwrite_ac_fault;

  assign o_write_page_fault   = r_page_fault | w_live_pf;
  assign o_write_ac_fault     = r_ac_fault | w_live_ac;
  assign o_write_fault_second = r_fault_second |
                                ((w_live_pf | w_live_ac) & (r_state == S_SECOND));

  assign w_accept = i_write_do & ~i_wr_reset & ~o_write_page_fault & ~o_write_ac_fault;

  always_comb begin
    w_next            = r_state;
    o_tlbwrite_do     = 1'b0;
    o_tlbwrite_second = 1'b0;
    o_write_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          o_tlbwrite_do = 1'b1;
          w_next        = S_FIRST;
        end
      end
      S_FIRST: begin
        o_tlbwrite_do = 1'b1;
        if (w_tlb_fault) begin
          w_next = S_IDLE;
        end else if (i_tlbwrite_done) begin
          if (r_len2 != '0 && !r_reset_waiting) begin
            w_next = S_SECOND;
          end else begin
            w_next       = S_IDLE;
            o_write_done = (r_len2 == '0) & ~r_reset_waiting;
          end
        end
      end
      S_SECOND: begin
        o_tlbwrite_do     = 1'b1;
        o_tlbwrite_second = 1'b1;
        if (w_tlb_fault) begin
          w_next = S_IDLE;
        end else if (i_tlbwrite_done) begin
          w_next       = S_IDLE;
          o_write_done = ~r_reset_waiting;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_len2          <= '0;
      r_addr2         <= '0;
      r_data2         <= '0;
      r_reset_waiting <= 1'b0;
      r_page_fault    <= 1'b0;
      r_ac_fault      <= 1'b0;
      r_fault_second  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_accept) begin
        r_len2  <= w_len2;
        r_addr2 <= w_addr2;
        r_data2 <= w_data2;
      end
      if (r_state == S_IDLE) r_reset_waiting <= 1'b0;
      else                   r_reset_waiting <= r_reset_waiting | i_wr_reset;
      if (i_wr_reset) begin
        r_page_fault   <= 1'b0;
        r_ac_fault     <= 1'b0;
        r_fault_second <= 1'b0;
      end else if (w_live_pf | w_live_ac) begin
        r_page_fault   <= r_page_fault | w_live_pf;
        r_ac_fault     <= r_ac_fault | w_live_ac;
        r_fault_second <= (r_state == S_SECOND);
      end
    end
  end

  assign o_tlbwrite_cpl         = i_write_cpl;
  assign o_tlbwrite_lock        = i_write_lock;
  assign o_tlbwrite_rmw         = i_write_rmw;
  assign o_tlbwrite_length_full = i_write_length;
  assign o_tlbwrite_address     = o_tlbwrite_second ? r_addr2 : i_write_address;
  assign o_tlbwrite_length      = o_tlbwrite_second ? r_len2  : w_len1;
  assign o_tlbwrite_data        = o_tlbwrite_second ? r_data2 : i_write_data;

  for (genvar g = 0; g < MAX_BYTES; g++) begin : g_be
    assign o_tlbwrite_be[g] = (32'(g) < 32'(o_tlbwrite_length));
  end

endmodule

// File: tb/tb_memory_write_split.sv
// Scoreboard bench for memory_write_split: a 16/4 instance with directed writes,
// faults, resets and address wrap, plus a 64/8 instance for the wide split case.
module tb_memory_write_split;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [7:0]  be;
    logic [63:0] data;
    logic        second;
  } piece_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  piece_t q4[$];
  piece_t q8[$];

  // 16/4 instance
  logic        wr_reset = 0, write_do = 0, write_lock = 0, write_rmw = 0;
  logic [1:0]  write_cpl = 0;
  logic [31:0] write_address = 0;
  logic [2:0]  write_length = 0;
  logic [31:0] write_data = 0;
  logic        tlb_done = 0, tlb_pf = 0, tlb_ac = 0;
  logic        write_done, write_pf, write_ac, write_fs;
  logic        tlb_do, tlb_lock, tlb_rmw, tlb_second;
  logic [1:0]  tlb_cpl;
  logic [2:0]  tlb_len_full, tlb_len;
  logic [31:0] tlb_addr, tlb_data;
  logic [3:0]  tlb_be;

  memory_write_split #(.LINE_BYTES(16), .MAX_BYTES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_wr_reset(wr_reset), .i_write_do(write_do),
    .o_write_done(write_done), .o_write_page_fault(write_pf), .o_write_ac_fault(write_ac),
    .o_write_fault_second(write_fs), .i_write_cpl(write_cpl), .i_write_address(write_address),
    .i_write_length(write_length), .i_write_lock(write_lock), .i_write_rmw(write_rmw),
    .i_write_data(write_data), .o_tlbwrite_do(tlb_do), .i_tlbwrite_done(tlb_done),
    .i_tlbwrite_page_fault(tlb_pf), .i_tlbwrite_ac_fault(tlb_ac), .o_tlbwrite_cpl(tlb_cpl),
    .o_tlbwrite_lock(tlb_lock), .o_tlbwrite_rmw(tlb_rmw), .o_tlbwrite_length_full(tlb_len_full),
    .o_tlbwrite_address(tlb_addr), .o_tlbwrite_length(tlb_len), .o_tlbwrite_data(tlb_data),
    .o_tlbwrite_be(tlb_be), .o_tlbwrite_second(tlb_second)
  );

  // 64/8 instance
  logic        write_do8 = 0;
  logic [31:0] write_address8 = 0;
  logic [3:0]  write_length8 = 0;
  logic [63:0] write_data8 = 0;
  logic        tlb_done8 = 0;
  logic        write_done8, write_pf8, write_ac8, write_fs8;
  logic        tlb_do8, tlb_lock8, tlb_rmw8, tlb_second8;
  logic [1:0]  tlb_cpl8;
  logic [3:0]  tlb_len_full8, tlb_len8;
  logic [31:0] tlb_addr8;
  logic [63:0] tlb_data8;
  logic [7:0]  tlb_be8;

  memory_write_split #(.LINE_BYTES(64), .MAX_BYTES(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .i_wr_reset(1'b0), .i_write_do(write_do8),
    .o_write_done(write_done8), .o_write_page_fault(write_pf8), .o_write_ac_fault(write_ac8),
    .o_write_fault_second(write_fs8), .i_write_cpl(2'b00), .i_write_address(write_address8),
    .i_write_length(write_length8), .i_write_lock(1'b0), .i_write_rmw(1'b0),
    .i_write_data(write_data8), .o_tlbwrite_do(tlb_do8), .i_tlbwrite_done(tlb_done8),
    .i_tlbwrite_page_fault(1'b0), .i_tlbwrite_ac_fault(1'b0), .o_tlbwrite_cpl(tlb_cpl8),
    .o_tlbwrite_lock(tlb_lock8), .o_tlbwrite_rmw(tlb_rmw8), .o_tlbwrite_length_full(tlb_len_full8),
    .o_tlbwrite_address(tlb_addr8), .o_tlbwrite_length(tlb_len8), .o_tlbwrite_data(tlb_data8),
    .o_tlbwrite_be(tlb_be8), .o_tlbwrite_second(tlb_second8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic piece_t mk(input logic [31:0] a, input logic [3:0] l, input logic [7:0] be,
                                input logic [63:0] d, input logic s);
    piece_t p;
    p.addr = a; p.len = l; p.be = be; p.data = d; p.second = s;
    return p;
  endfunction

  // TLB model for the 16/4 instance: answers each piece rsp_n cycles after it is requested.
  int rsp_n = 1;
  int fault_piece = 0;
  bit fault_ac = 0;
  int cnt4 = 0;
  int cnt8 = 0;
  always @(posedge clk) begin
    #2;
    tlb_done = 0; tlb_pf = 0; tlb_ac = 0; tlb_done8 = 0;
    if (!tlb_do) cnt4 = 0;
    else if (cnt4 >= rsp_n) begin
      cnt4 = 0;
      if (fault_piece == (tlb_second ? 2 : 1)) begin
        if (fault_ac) tlb_ac = 1; else tlb_pf = 1;
      end else tlb_done = 1;
    end else cnt4++;
    if (!tlb_do8) cnt8 = 0;
    else if (cnt8 >= 1) begin cnt8 = 0; tlb_done8 = 1; end
    else cnt8++;
  end

  // Monitors: pop an expected piece whenever the TLB answers a request.
  int done_cnt4 = 0;
  piece_t act4, exp4, act8, exp8;
  always @(negedge clk) begin
    if (rst_n) begin
      if (tlb_do && (tlb_done || tlb_pf || tlb_ac)) begin
        act4 = mk(tlb_addr, 4'(tlb_len), 8'(tlb_be), 64'(tlb_data), tlb_second);
        n_vec++;
        if (q4.size() == 0) begin
          n_err++;
          $display("FAIL piece4_unexpected: got addr %h len %0d", act4.addr, act4.len);
        end else begin
          exp4 = q4.pop_front();
          if (act4 !== exp4) begin
            n_err++;
            $display("FAIL piece4: got addr %h len %0d be %h data %h sec %b expected addr %h len %0d be %h data %h sec %b",
                     act4.addr, act4.len, act4.be, act4.data, act4.second,
                     exp4.addr, exp4.len, exp4.be, exp4.data, exp4.second);
          end
        end
      end
      if (write_done) begin
        done_cnt4++;
        chk("done_fault_exclusive", {write_pf, write_ac}, 0);
      end
      if (tlb_do8 && tlb_done8) begin
        act8 = mk(tlb_addr8, tlb_len8, tlb_be8, tlb_data8, tlb_second8);
        n_vec++;
        if (q8.size() == 0) begin
          n_err++;
          $display("FAIL piece8_unexpected: got addr %h len %0d", act8.addr, act8.len);
        end else begin
          exp8 = q8.pop_front();
          if (act8 !== exp8) begin
            n_err++;
            $display("FAIL piece8: got addr %h len %0d be %h data %h sec %b expected addr %h len %0d be %h data %h sec %b",
                     act8.addr, act8.len, act8.be, act8.data, act8.second,
                     exp8.addr, exp8.len, exp8.be, exp8.data, exp8.second);
          end
        end
      end
    end
  end

  // Issue a write and wait (bounded) for write_done or a fault; write_do stays high.
  task automatic do_write(input string name, input logic [31:0] a, input logic [2:0] l,
                          input logic [31:0] d, input int exp_lat, input bit exp_fault);
    int lat;
    @(posedge clk); #1;
    write_address = a; write_length = l; write_data = d; write_do = 1;
    @(negedge clk);
    chk({name, "_accept"}, tlb_do, 1);
    lat = 0;
    while (!(write_done || write_pf || write_ac) && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_outcome"}, {write_done, write_pf | write_ac}, exp_fault ? 2'b01 : 2'b10);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    write_do = 0; wr_reset = 0;
  endtask

  int do_cycles, dones_before, lat8;

  initial begin
    // reset state with a split-looking request on the inputs
    write_address = 32'h1000_000E; write_length = 4; write_data = 32'hDDCC_BBAA;
    write_cpl = 2'b10; write_lock = 1; write_rmw = 0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {tlb_do, write_done, write_pf, write_ac, write_fs, tlb_second}, 0);
    chk("reset_be", tlb_be, 4'h3);
    chk("reset_len1", tlb_len, 2);
    chk("passthrough", {tlb_cpl, tlb_lock, tlb_rmw, tlb_len_full}, {2'b10, 1'b1, 1'b0, 3'd4});
    chk("reset_outputs8", {tlb_do8, write_done8, tlb_second8}, 0);
    @(posedge clk); #1; rst_n = 1;
    write_lock = 0; write_cpl = 0;

    // split write across a 16-byte line
    q4.push_back(mk(32'h1000_000E, 2, 8'h03, 64'hDDCC_BBAA, 0));
    q4.push_back(mk(32'h1000_0010, 2, 8'h03, 64'h0000_DDCC, 1));
    do_write("split", 32'h1000_000E, 4, 32'hDDCC_BBAA, 3, 0);

    // single piece, then a back-to-back write accepted the next cycle
    q4.push_back(mk(32'h0000_0104, 4, 8'h0F, 64'h1122_3344, 0));
    do_write("single", 32'h0000_0104, 4, 32'h1122_3344, 1, 0);
    q4.push_back(mk(32'h0000_0201, 3, 8'h07, 64'h00AA_BBCC, 0));
    do_write("b2b", 32'h0000_0201, 3, 32'h00AA_BBCC, 1, 0);
    go_idle();

    // slower TLB: split latency is 2N+1
    rsp_n = 2;
    q4.push_back(mk(32'h0000_002F, 1, 8'h01, 64'h0000_5566, 0));
    q4.push_back(mk(32'h0000_0030, 1, 8'h01, 64'h0000_0055, 1));
    do_write("split_n2", 32'h0000_002F, 2, 32'h0000_5566, 5, 0);
    go_idle();
    rsp_n = 1;

    // page fault on piece 2: sticky, blocks write_do until wr_reset
    fault_piece = 2; fault_ac = 0;
    q4.push_back(mk(32'h1000_000E, 2, 8'h03, 64'hDDCC_BBAA, 0));
    q4.push_back(mk(32'h1000_0010, 2, 8'h03, 64'h0000_DDCC, 1));
    do_write("pf2", 32'h1000_000E, 4, 32'hDDCC_BBAA, 3, 1);
    chk("pf2_live", {write_pf, write_ac, write_fs}, 3'b101);
    fault_piece = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("pf2_sticky", {tlb_do, write_pf, write_ac, write_fs}, 4'b0101);
    end
    @(posedge clk); #1; wr_reset = 1; write_do = 0;
    @(posedge clk); #1; wr_reset = 0;
    @(negedge clk);
    chk("pf2_cleared", {write_pf, write_ac, write_fs}, 0);
    q4.push_back(mk(32'h0000_0104, 4, 8'h0F, 64'hCAFE_F00D, 0));
    do_write("after_clear", 32'h0000_0104, 4, 32'hCAFE_F00D, 1, 0);
    go_idle();

    // alignment fault on piece 1 reports fault_second=0
    fault_piece = 1; fault_ac = 1;
    q4.push_back(mk(32'h1000_000E, 2, 8'h03, 64'hDDCC_BBAA, 0));
    do_write("ac1", 32'h1000_000E, 4, 32'hDDCC_BBAA, 1, 1);
    fault_piece = 0; fault_ac = 0;
    @(negedge clk);
    chk("ac1_sticky", {write_pf, write_ac, write_fs}, 3'b010);
    @(posedge clk); #1; wr_reset = 1; write_do = 0;
    @(posedge clk); #1; wr_reset = 0;
    @(negedge clk);
    chk("ac1_cleared", {write_pf, write_ac, write_fs}, 0);

    // wr_reset while piece 1 is in flight: result dropped, no piece 2
    rsp_n = 3;
    dones_before = done_cnt4;
    do_cycles = 0;
    q4.push_back(mk(32'h1000_000E, 2, 8'h03, 64'hDDCC_BBAA, 0));
    @(posedge clk); #1; write_address = 32'h1000_000E; write_length = 4;
    write_data = 32'hDDCC_BBAA; write_do = 1;
    @(negedge clk); do_cycles += int'(tlb_do);
    @(posedge clk); #1; wr_reset = 1; write_do = 0;
    @(negedge clk); do_cycles += int'(tlb_do);
    @(posedge clk); #1; wr_reset = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); do_cycles += int'(tlb_do);
    end
    chk("abort_do_cycles", do_cycles, 4);
    chk("abort_no_done", done_cnt4 - dones_before, 0);

    // wr_reset coinciding with tlbwrite_done still completes the write
    rsp_n = 2;
    q4.push_back(mk(32'h0000_0104, 4, 8'h0F, 64'h1357_9BDF, 0));
    @(posedge clk); #1; write_address = 32'h0000_0104; write_length = 4;
    write_data = 32'h1357_9BDF; write_do = 1;
    @(posedge clk);
    @(posedge clk); #1; wr_reset = 1;
    @(negedge clk);
    chk("reset_same_cycle_done", write_done, 1);
    go_idle();
    rsp_n = 1;

    // piece 2 address wraps past 0xFFFFFFFF
    q4.push_back(mk(32'hFFFF_FFFE, 2, 8'h03, 64'h4433_2211, 0));
    q4.push_back(mk(32'h0000_0000, 2, 8'h03, 64'h0000_4433, 1));
    do_write("wrap", 32'hFFFF_FFFE, 4, 32'h4433_2211, 3, 0);
    go_idle();

    // asynchronous reset while piece 2 is outstanding
    rsp_n = 3;
    dones_before = done_cnt4;
    q4.push_back(mk(32'h1000_000E, 2, 8'h03, 64'hDDCC_BBAA, 0));
    @(posedge clk); #1; write_address = 32'h1000_000E; write_length = 4;
    write_data = 32'hDDCC_BBAA; write_do = 1;
    for (int i = 0; i < 20 && !tlb_second; i++) @(negedge clk);
    chk("rst_reached_second", tlb_second, 1);
    @(posedge clk); #1; rst_n = 0; write_do = 0;
    #1;
    chk("rst_outputs", {tlb_do, write_done, write_pf, write_ac, write_fs, tlb_second}, 0);
    chk("rst_be", tlb_be, 4'h3);
    @(posedge clk); #1; rst_n = 1;
    repeat (4) @(negedge clk);
    chk("rst_no_done", done_cnt4 - dones_before, 0);
    chk("rst_idle", tlb_do, 0);
    rsp_n = 1;

    // 64-byte line, 8-byte write
    q8.push_back(mk(32'h0000_003D, 3, 8'h07, 64'h8877_6655_4433_2211, 0));
    q8.push_back(mk(32'h0000_0040, 5, 8'h1F, 64'h0000_0088_7766_5544, 1));
    @(posedge clk); #1; write_address8 = 32'h0000_003D; write_length8 = 8;
    write_data8 = 64'h8877_6655_4433_2211; write_do8 = 1;
    @(negedge clk);
    lat8 = 0;
    while (!write_done8 && lat8 < 50) begin
      @(negedge clk);
      lat8++;
    end
    chk("wide_latency", lat8, 3);
    @(posedge clk); #1; write_do8 = 0;
    repeat (2) @(negedge clk);

    chk("q4_drained", q4.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
